// File: rtl/fp_alu_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fp_alu_arbiter
//
// Shares one fixed-latency floating-point ALU (add/sub/mul/div, no handshake)
// among N_REQ requesters. One operation is in flight at a time: a request is
// accepted in IDLE, its operands are registered onto the ALU inputs, the block
// waits ALU_LATENCY cycles in EXEC, captures alu_result and presents it in RESP
// to the requester that owns the operation.
//
// Build option:
//   FP_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                      round-robin pointer held at 0.
//                         undefined -> round-robin starting at ptr (default).
//
// Handshake semantics (both directions):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The requester holds req_valid[i] and its operands stable until req_ready[i];
//   the arbiter holds rsp_valid[i] and rsp_result stable until rsp_ready[i].
//   req_ready is combinational and only ever asserted in IDLE; rsp_valid is
//   only ever asserted in RESP, and rsp_ready from non-owners is ignored.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   req_valid/ready  per-requester request handshake (ready is one-hot)
//   req_a/req_b      packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_op           packed ops, requester i at [i*2 +: 2] (00 add 01 sub 10 mul 11 div)
//   rsp_valid/ready  per-requester response handshake (valid is one-hot)
//   rsp_result       shared result bus, meaningful only with rsp_valid
//   alu_a/b/op       registered ALU operands, stable for the whole operation
//   alu_result       ALU output, sampled ALU_LATENCY cycles after operands settle
//   busy             1 whenever the FSM is not in IDLE
//   dbg_state        current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// -----------------------------------------------------------------------------
module fp_alu_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ALU_LATENCY = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [N_REQ*2-1:0]          req_op,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_result,
    output logic [DATA_WIDTH-1:0]       alu_a,
    output logic [DATA_WIDTH-1:0]       alu_b,
    output logic [1:0]                  alu_op,
    input  logic [DATA_WIDTH-1:0]       alu_result,
    output logic                        busy,
    output logic [1:0]                  dbg_state
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    if (ALU_LATENCY < 1) begin : g_bad_latency
        $error("fp_alu_arbiter: ALU_LATENCY must be >= 1");
    end
    if (N_REQ < 2) begin : g_bad_nreq
        $error("fp_alu_arbiter: N_REQ must be >= 2");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [1:0]              alu_op_q, alu_op_d;

    // Winner selection. Round-robin scans from ptr and wraps; fixed priority
    // scans from index 0. The first valid requester found wins.
    logic [PTR_W-1:0] win;
    logic             found;

    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
            idx = i;
`else
            idx = (int'(ptr_q) + i) % N_REQ;
`endif
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        rsp_result_d = rsp_result_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        req_ready    = '0;
        rsp_valid    = '0;

        case (state_q)
            ST_IDLE: begin
                // reset gating keeps a grant from being seen on an edge that
                // the register reset will discard anyway
                if (found && !reset) begin
                    req_ready = ONE_HOT0 << win;
                    alu_a_d   = req_a[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    alu_b_d   = req_b[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    alu_op_d  = req_op[int'(win)*2 +: 2];
                    owner_d   = win;
                    cnt_d     = '0;
`ifdef FP_ARB_FIXED_PRIO_EN
                    ptr_d     = ptr_q;
`else
                    if (int'(win) == N_REQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win + PTR_W'(1);
                    end
`endif
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    rsp_result_d = alu_result;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = ONE_HOT0 << owner_q;
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            rsp_result_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            rsp_result_q <= rsp_result_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
        end
    end

    assign rsp_result = rsp_result_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign busy       = (state_q != ST_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fp_alu_arbiter.sv
`timescale 1ns/1ps
// Directed testbench for fp_alu_arbiter with a registered 3-cycle ALU model.
module tb_fp_alu_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N*2-1:0]   req_op;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [W-1:0]     rsp_result;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [1:0]       alu_op;
    logic [W-1:0]     alu_result;
    logic             busy;
    logic [1:0]       dbg_state;

    fp_alu_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .ALU_LATENCY(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- ALU model ----------------
    // Hand-computed IEEE-754 single results for the operand sets used here;
    // any other combination yields a distinct non-FP pattern.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
        if (op == 2'b00 && a == 32'h4144CCCD && b == 32'h4059999A) return 32'h417B3333; // 12.3+3.4
        if (op == 2'b10 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000; // 2*3
        if (op == 2'b01 && a == 32'h3F800000 && b == 32'h3F000000) return 32'h3F000000; // 1-0.5
        if (op == 2'b11 && a == 32'h41000000 && b == 32'h40000000) return 32'h40800000; // 8/2
        return a ^ b ^ {30'b0, op};
    endfunction

    // Two register stages: result is valid in the third cycle after operands settle.
    logic [W-1:0] alu_s0, alu_s1;
    always_ff @(posedge clk) begin
        alu_s0 <= alu_fn(alu_a, alu_b, alu_op);
        alu_s1 <= alu_s0;
    end
    assign alu_result = alu_s1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];
    logic [1:0]   op_c [N];
    logic [W-1:0] exp_q[$];
    int           own_q[$];
    int           grant_log[$];
    int           grant_cyc[$];
    int           cyc;
    int           n_tests;
    int           n_fail;
    int           exp2[5];
    int           exp6[4];
    logic [N-1:0] exp3_next;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- driver: one clock cycle with monitoring ----------------
    task automatic tick();
        int w;
        #2;
        if (reset) begin
            exp_q.delete();
            own_q.delete();
        end else begin
            if (req_ready != '0) begin
                check_eq("grant_onehot", 32'($countones(req_ready)), 32'd1);
                w = oh_idx(req_ready);
                grant_log.push_back(w);
                grant_cyc.push_back(cyc);
                exp_q.push_back(alu_fn(op_a[w], op_b[w], op_c[w]));
                own_q.push_back(w);
            end
            if (rsp_valid != '0) begin
                check_eq("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
                if ((rsp_valid & rsp_ready) != '0) begin
                    if (exp_q.size() == 0) begin
                        check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end else begin
                        check_eq("rsp_result", rsp_result, exp_q.pop_front());
                        check_eq("rsp_owner", oh_idx(rsp_valid), own_q.pop_front());
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            tick();
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_grants(input int n, input string tag);
        for (int i = 0; i < 60; i++) begin
            if (grant_log.size() >= n) break;
            tick();
        end
        check_eq(tag, 32'(grant_log.size() >= n), 32'd1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        op_a[0] = 32'h4144CCCD; op_b[0] = 32'h4059999A; op_c[0] = 2'b00;
        op_a[1] = 32'h40000000; op_b[1] = 32'h40400000; op_c[1] = 2'b10;
        op_a[2] = 32'h3F800000; op_b[2] = 32'h3F000000; op_c[2] = 2'b01;
        op_a[3] = 32'h41000000; op_b[3] = 32'h40000000; op_c[3] = 2'b11;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
            req_op[i*2 +: 2] = op_c[i];
        end
`ifdef FP_ARB_FIXED_PRIO_EN
        exp2 = '{0, 0, 0, 0, 0};
        exp6 = '{0, 0, 0, 0};
        exp3_next = 4'b0001;
`else
        exp2 = '{0, 1, 2, 3, 0};
        exp6 = '{0, 3, 0, 3};
        exp3_next = 4'b0100;
`endif

        // Reset values
        reset = 1'b1; req_valid = '0; rsp_ready = '0;
        tick(); tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_result", rsp_result, 32'd0);
        check_eq("rst_alu_a", alu_a, 32'd0);
        check_eq("rst_alu_b", alu_b, 32'd0);
        check_eq("rst_alu_op", 32'(alu_op), 32'd0);
        req_valid = 4'hF; #1;
        check_eq("rst_ready_gated", 32'(req_ready), 32'd0);
        req_valid = '0;

        // 1: single request, latency and result
        reset = 1'b0; rsp_ready = 4'b0001; req_valid = 4'b0001; #1;
        check_eq("t1_ready_c0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check_eq("t1_alu_a_c1", alu_a, 32'h4144CCCD);
        check_eq("t1_alu_b_c1", alu_b, 32'h4059999A);
        check_eq("t1_alu_op_c1", 32'(alu_op), 32'd0);
        check_eq("t1_busy_c1", 32'(busy), 32'd1);
        check_eq("t1_rsp_c1", 32'(rsp_valid), 32'd0);
        tick();
        check_eq("t1_alu_a_c2", alu_a, 32'h4144CCCD);
        check_eq("t1_rsp_c2", 32'(rsp_valid), 32'd0);
        tick();
        check_eq("t1_rsp_c3", 32'(rsp_valid), 32'd0);
        tick();
        check_eq("t1_rsp_valid_c4", 32'(rsp_valid), 32'h1);
        check_eq("t1_rsp_result_c4", rsp_result, 32'h417B3333);
        tick();
        check_eq("t1_idle_c5", 32'(busy), 32'd0);

        // 2: all requesters valid from reset -> order and spacing
        reset = 1'b1; req_valid = 4'hF; rsp_ready = 4'hF;
        tick(); #1;
        check_eq("t2_ready_in_reset", 32'(req_ready), 32'd0);
        reset = 1'b0;
        grant_log.delete(); grant_cyc.delete();
        wait_grants(5, "t2_grant_timeout");
        for (int i = 0; i < 5; i++) check_eq("t2_grant_order", grant_log[i], exp2[i]);
        for (int i = 1; i < 5; i++) check_eq("t2_grant_spacing", grant_cyc[i] - grant_cyc[i-1], 32'd5);
        req_valid = '0;
        wait_idle("t2_drain");

        // 3: response backpressure on requester 1
        req_valid = 4'b0010; rsp_ready = '0; #1;
        check_eq("t3_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1101;
        tick(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            check_eq("t3_hold_valid", 32'(rsp_valid), 32'h2);
            check_eq("t3_hold_result", rsp_result, 32'h40C00000);
            check_eq("t3_hold_busy", 32'(busy), 32'd1);
            check_eq("t3_no_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 4'b0010;
        tick();
        check_eq("t3_idle_after_release", 32'(busy), 32'd0);
        #1;
        check_eq("t3_next_grant", 32'(req_ready), 32'(exp3_next));
        tick();
        req_valid = '0; rsp_ready = 4'hF;
        wait_idle("t3_drain");

        // 4: reset during EXEC of a req2 operation
        req_valid = 4'b0100; #1;
        check_eq("t4_grant_req2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        check_eq("t4_busy_exec", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; req_valid = 4'b1010;
        check_eq("t4_state_after_reset", 32'(dbg_state), 32'd0);
        check_eq("t4_rsp_after_reset", 32'(rsp_valid), 32'd0);
        #1;
        check_eq("t4_next_grant_req1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        wait_idle("t4_drain");

        // 5: non-owner rsp_ready ignored in RESP
        req_valid = 4'b0001; rsp_ready = 4'b1000; #1;
        check_eq("t5_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("t5_state_resp", 32'(dbg_state), 32'd2);
            check_eq("t5_rsp_valid", 32'(rsp_valid), 32'h1);
            tick();
        end
        rsp_ready = 4'b0001;
        wait_idle("t5_drain");

        // 6: req0 and req3 contending
        reset = 1'b1;
        tick();
        reset = 1'b0; rsp_ready = 4'hF; req_valid = 4'b1001;
        grant_log.delete(); grant_cyc.delete();
        wait_grants(4, "t6_grant_timeout");
        for (int i = 0; i < 4; i++) check_eq("t6_grant_order", grant_log[i], exp6[i]);
        req_valid = '0;
        wait_idle("t6_drain");

        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
